// File: rtl/sclk_burst_gen.sv
// Programmable SPI SCLK burst generator: even divide 2*(div_i+1), CPOL idle level, bits_i periods per start.
// All outputs registered; start accepted only in IDLE with abort_i low, abort/reset return to idle next cycle.
module sclk_burst_gen #(
  parameter int G_DIV_WIDTH = 8,
  parameter int G_CNT_WIDTH = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [G_DIV_WIDTH-1:0] div_i,
  input  logic                   cpol_i,
  input  logic [G_CNT_WIDTH-1:0] bits_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  output logic                   sclk_o,
  output logic                   busy_o,
  output logic                   lead_o,
  output logic                   trail_o,
  output logic                   done_o
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                 state_q;
  logic [G_DIV_WIDTH-1:0] div_q;
  logic [G_DIV_WIDTH-1:0] half_q;
  logic [G_DIV_WIDTH-1:0] half_d;
  logic [G_CNT_WIDTH-1:0] bits_q;
  logic [G_CNT_WIDTH-1:0] per_q;
  logic [G_CNT_WIDTH-1:0] per_d;
  logic                   cpol_q;
  logic                   sclk_q;
  logic                   busy_q;
  logic                   lead_q;
  logic                   trail_q;
  logic                   done_q;

  assign half_d = half_q + 1'b1;
  assign per_d  = per_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      half_q  <= '0;
      bits_q  <= '0;
      per_q   <= '0;
      cpol_q  <= 1'b0;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      lead_q  <= 1'b0;
      trail_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      lead_q  <= 1'b0;
      trail_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          sclk_q <= cpol_i;
          if (start_i && !abort_i) begin
            if (bits_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              div_q   <= div_i;
              cpol_q  <= cpol_i;
              bits_q  <= bits_i;
              half_q  <= '0;
              per_q   <= '0;
            end
          end
        end
        ST_RUN: begin
          if (abort_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            sclk_q  <= cpol_q;
            half_q  <= '0;
            per_q   <= '0;
          end else if (half_q == div_q) begin
            half_q <= '0;
            sclk_q <= ~sclk_q;
            // Leaving the idle level is a lead edge; returning to it is a trail.
            if (sclk_q == cpol_q) begin
              lead_q <= 1'b1;
            end else begin
              trail_q <= 1'b1;
              per_q   <= per_d;
              if (per_d == bits_q) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end
          end else begin
            half_q <= half_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sclk_o  = sclk_q;
  assign busy_o  = busy_q;
  assign lead_o  = lead_q;
  assign trail_o = trail_q;
  assign done_o  = done_q;

endmodule
